// File: rtl/cpu_types_pkg.sv
// Shared types for the 5-stage core's pipeline control.
//   pctl_state_t : pipeline control FSM state
//   pctl_dec_t   : one cycle's control decision (PC enable, per-latch enable/flush, next state)
//   run_rules    : prioritised RUN-state decision shared by RUN, LWBUB and DWAIT (on dhit)
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    LWBUB  = 2'd2,
    HALTED = 2'd3
  } pctl_state_t;

  // Latch vectors are ordered {IF/ID, ID/EX, EX/MEM, MEM/WB}.
  typedef struct packed {
    logic        pc_en;
    logic [3:0]  en;
    logic [3:0]  flush;
    logic        dstall;  // this cycle is a dmem-miss stall
    pctl_state_t nxt;
  } pctl_dec_t;

  function automatic pctl_dec_t run_rules(input logic halt_mem, input logic mem_busy,
                                          input logic dhit, input logic branch,
                                          input logic lw, input logic jump, input logic ihit);
    pctl_dec_t d;
    d.pc_en  = 1'b1;
    d.en     = 4'b1111;
    d.flush  = 4'b0000;
    d.dstall = 1'b0;
    d.nxt    = RUN;
    if (halt_mem) begin
      // Drain only the HALT itself into MEM/WB; everything younger is squashed.
      d.pc_en = 1'b0;
      d.flush = 4'b1110;
      d.nxt   = HALTED;
    end else if (mem_busy && !dhit) begin
      // Freeze the front of the pipe, push a bubble into MEM/WB.
      d.pc_en  = 1'b0;
      d.en     = 4'b0001;
      d.flush  = 4'b0001;
      d.dstall = 1'b1;
      d.nxt    = DWAIT;
    end else if (branch) begin
      d.flush = 4'b1110;
    end else if (lw) begin
      d.pc_en = 1'b0;
      d.en    = 4'b0111;
      d.flush = 4'b0100;
      d.nxt   = LWBUB;
    end else if (jump) begin
      d.flush = 4'b1000;
    end else if (!ihit) begin
      d.pc_en = 1'b0;
      d.flush = 4'b1000;
    end
    return d;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count up by one (ignored once at MAX)
//   clr      : synchronous clear, wins over en
//   cnt      : current count
//   at_max   : cnt == MAX
module sat_counter #(
  parameter int unsigned   W   = 8,
  parameter logic [W-1:0]  MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == MAX);
  assign cnt    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !at_max) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline control for the 5-stage core: drives PC enable and per-latch enable/flush for
// IF/ID, ID/EX, EX/MEM, MEM/WB from cache hits, load-use hazard, branch/jump and halt.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   ihit, dhit               icache / dcache hit
//   dmemREN_MEM, dmemWEN_MEM MEM-stage load / store in flight
//   lw_hazard, jump_ID       load-use hazard, jump decoded in ID
//   branch_MEM, halt_MEM     taken branch / HALT at EX/MEM output
//   pc_en, en_*, flush_*     PC load enable, latch enables and bubble-load (flush wins)
//   halt                     sticky halted flag
//   stall_cnt                saturating count of non-halted cycles with pc_en=0
//   dwait_err                sticky: dmem wait reached DWAIT_MAX cycles
module pipeline_control_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DWAIT_MAX = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_MEM,
  input  logic             dmemWEN_MEM,
  input  logic             lw_hazard,
  input  logic             jump_ID,
  input  logic             branch_MEM,
  input  logic             halt_MEM,
  output logic             pc_en,
  output logic             en_IFID,
  output logic             en_IDEX,
  output logic             en_EXMEM,
  output logic             en_MEMWB,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             flush_EXMEM,
  output logic             flush_MEMWB,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             dwait_err
);

  localparam int unsigned WAIT_W = $clog2(DWAIT_MAX + 1);

  pctl_state_t       state_q, state_d;
  logic              halt_q, dwait_err_q;
  pctl_dec_t         dec, ctl;
  logic              mem_busy;
  logic              stall_inc, stall_at_max;
  logic              wait_en, wait_clr, wait_at_max, wait_hit;
  logic [WAIT_W-1:0] wait_cnt;

  assign mem_busy = dmemREN_MEM | dmemWEN_MEM;

  always_comb begin
    dec = '0;
    unique case (state_q)
      RUN:    dec = run_rules(halt_MEM, mem_busy, dhit, branch_MEM, lw_hazard, jump_ID, ihit);
      // The bubble just inserted already covers the hazard; never insert a second one.
      LWBUB:  dec = run_rules(halt_MEM, mem_busy, dhit, branch_MEM, 1'b0, jump_ID, ihit);
      DWAIT: begin
        if (dhit) begin
          dec = run_rules(halt_MEM, mem_busy, dhit, branch_MEM, lw_hazard, jump_ID, ihit);
        end else begin
          // Keep stalling regardless of what else is pending behind the miss.
          dec = run_rules(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
      end
      HALTED: begin
        dec.pc_en  = 1'b0;
        dec.en     = 4'b0000;
        dec.flush  = 4'b0000;
        dec.dstall = 1'b0;
        dec.nxt    = HALTED;
      end
    endcase
    state_d = dec.nxt;

    ctl = dec;
    if (RST) begin
      ctl.pc_en = 1'b0;
      ctl.en    = 4'b0000;
      ctl.flush = 4'b1111;
    end
  end

  assign pc_en       = ctl.pc_en;
  assign en_IFID     = ctl.en[3];
  assign en_IDEX     = ctl.en[2];
  assign en_EXMEM    = ctl.en[1];
  assign en_MEMWB    = ctl.en[0];
  assign flush_IFID  = ctl.flush[3];
  assign flush_IDEX  = ctl.flush[2];
  assign flush_EXMEM = ctl.flush[1];
  assign flush_MEMWB = ctl.flush[0];

  // Counters freeze once halted.
  assign stall_inc = (state_q != HALTED) && !dec.pc_en && !stall_at_max;
  assign wait_en   = dec.dstall && !wait_at_max;
  assign wait_clr  = !dec.dstall && (state_q != HALTED);
  assign wait_hit  = (wait_cnt == WAIT_W'(DWAIT_MAX));

  sat_counter #(
    .W   (CNT_W),
    .MAX ({CNT_W{1'b1}})
  ) u_stall_cnt (
    .clk    (CLK),
    .rst    (RST),
    .en     (stall_inc),
    .clr    (1'b0),
    .cnt    (stall_cnt),
    .at_max (stall_at_max)
  );

  sat_counter #(
    .W   (WAIT_W),
    .MAX (WAIT_W'(DWAIT_MAX))
  ) u_wait_cnt (
    .clk    (CLK),
    .rst    (RST),
    .en     (wait_en),
    .clr    (wait_clr),
    .cnt    (wait_cnt),
    .at_max (wait_at_max)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RUN;
      halt_q      <= 1'b0;
      dwait_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_q      <= (state_d == HALTED);
      dwait_err_q <= dwait_err_q | wait_hit;
    end
  end

  assign halt = halt_q;
  // Visible in the same cycle the wait count reaches the limit, then held by the flop.
  assign dwait_err = dwait_err_q | wait_hit;

endmodule

// File: tb/tb_pipeline_control_unit.sv
module tb_pipeline_control_unit;

  logic        CLK, RST;
  logic        ihit, dhit, dmemREN_MEM, dmemWEN_MEM, lw_hazard, jump_ID, branch_MEM, halt_MEM;
  logic        pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB;
  logic        flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB;
  logic        halt, dwait_err;
  logic [15:0] stall_cnt;
  logic [8:0]  ctl;

  int n_chk  = 0;
  int n_fail = 0;

  // Input vector: {ihit, dhit, ren, wen, lw, jump, branch, halt}
  // Control vector: {pc_en, en IFID/IDEX/EXMEM/MEMWB, flush IFID/IDEX/EXMEM/MEMWB}
  localparam logic [7:0] IDLE   = 8'b1100_0000;
  localparam logic [7:0] RDMISS = 8'b1010_0000;
  localparam logic [8:0] C_NORM = 9'b1_1111_0000;
  localparam logic [8:0] C_DSTL = 9'b0_0001_0001;
  localparam logic [8:0] C_BR   = 9'b1_1111_1110;
  localparam logic [8:0] C_LW   = 9'b0_0111_0100;
  localparam logic [8:0] C_HLT  = 9'b0_1111_1110;
  localparam logic [8:0] C_RST  = 9'b0_0000_1111;
  localparam logic [8:0] C_OFF  = 9'b0_0000_0000;

  typedef struct {
    logic [7:0] in;
    logic [8:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[14];

  pipeline_control_unit #(
    .CNT_W     (16),
    .DWAIT_MAX (64)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (ihit),
    .dhit        (dhit),
    .dmemREN_MEM (dmemREN_MEM),
    .dmemWEN_MEM (dmemWEN_MEM),
    .lw_hazard   (lw_hazard),
    .jump_ID     (jump_ID),
    .branch_MEM  (branch_MEM),
    .halt_MEM    (halt_MEM),
    .pc_en       (pc_en),
    .en_IFID     (en_IFID),
    .en_IDEX     (en_IDEX),
    .en_EXMEM    (en_EXMEM),
    .en_MEMWB    (en_MEMWB),
    .flush_IFID  (flush_IFID),
    .flush_IDEX  (flush_IDEX),
    .flush_EXMEM (flush_EXMEM),
    .flush_MEMWB (flush_MEMWB),
    .halt        (halt),
    .stall_cnt   (stall_cnt),
    .dwait_err   (dwait_err)
  );

  assign ctl = {pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
                flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [7:0] v);
    {ihit, dhit, dmemREN_MEM, dmemWEN_MEM, lw_hazard, jump_ID, branch_MEM, halt_MEM} = v;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the DUT in RUN just after a clock edge.
  task automatic do_reset();
    apply(IDLE);
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{8'b1100_0000, C_NORM,         "normal"};
    vecs[1]  = '{8'b0100_0000, 9'b0_1111_1000, "imiss"};
    vecs[2]  = '{8'b1100_0100, 9'b1_1111_1000, "jump"};
    vecs[3]  = '{8'b0100_0100, 9'b1_1111_1000, "jump_imiss"};
    vecs[4]  = '{8'b1100_1000, C_LW,           "lw"};
    vecs[5]  = '{8'b1100_1100, C_LW,           "lw_jump"};
    vecs[6]  = '{8'b1100_0010, C_BR,           "branch"};
    vecs[7]  = '{8'b0100_0110, C_BR,           "br_jump_imiss"};
    vecs[8]  = '{8'b1100_1010, C_BR,           "br_lw"};
    vecs[9]  = '{8'b1010_0000, C_DSTL,         "ren_miss"};
    vecs[10] = '{8'b1001_0010, C_DSTL,         "wen_miss_br"};
    vecs[11] = '{8'b1110_0000, C_NORM,         "ren_hit"};
    vecs[12] = '{8'b1100_0001, C_HLT,          "halt"};
    vecs[13] = '{8'b1010_0001, C_HLT,          "halt_over_miss"};

    RST = 1'b1;
    apply(IDLE);
    #2;
    chk("reset_ctl", 32'(ctl), 32'(C_RST));
    step();
    step();
    RST = 1'b0;
    #2;
    chk("reset_halt", 32'(halt), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_dwait_err", 32'(dwait_err), 32'd0);

    // Single-cycle RUN decisions, each from a fresh reset.
    for (int i = 0; i < 14; i++) begin
      do_reset();
      apply(vecs[i].in);
      #2;
      chk(vecs[i].name, 32'(ctl), 32'(vecs[i].exp));
    end

    // Reset mid-DWAIT: asynchronous return to RUN defaults.
    do_reset();
    apply(RDMISS);
    step();
    step();
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_ctl", 32'(ctl), 32'(C_RST));
    chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
    step();
    RST = 1'b0;
    apply(8'b1000_0000);  // dhit low with no access: stalls only if still in DWAIT
    #2;
    chk("midrst_run", 32'(ctl), 32'(C_NORM));
    chk("midrst_halt", 32'(halt), 32'd0);

    // Load miss for three cycles, then hit.
    do_reset();
    apply(RDMISS);
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("dwait3_stall", 32'(ctl), 32'(C_DSTL));
      step();
    end
    apply(8'b1110_0000);
    #2;
    chk("dwait3_release", 32'(ctl), 32'(C_NORM));
    step();
    chk("dwait3_stall_cnt", 32'(stall_cnt), 32'd3);

    // Load-use hazard held two cycles: a single bubble.
    do_reset();
    apply(8'b1100_1000);
    #2;
    chk("lw2_first", 32'(ctl), 32'(C_LW));
    step();
    #2;
    chk("lw2_second", 32'(ctl), 32'(C_NORM));
    step();
    apply(IDLE);
    chk("lw2_stall_cnt", 32'(stall_cnt), 32'd1);

    // Branch pending behind a dmem miss acts only once dhit arrives.
    do_reset();
    apply(8'b1010_0010);
    for (int k = 1; k <= 3; k++) begin
      #2;
      chk("brdw_hold", 32'(ctl), 32'(C_DSTL));
      step();
    end
    apply(8'b1110_0010);
    #2;
    chk("brdw_flush", 32'(ctl), 32'(C_BR));
    step();
    apply(IDLE);
    #2;
    chk("brdw_after", 32'(ctl), 32'(C_NORM));

    // Watchdog: 70 miss cycles, error at the 64th, then halt.
    do_reset();
    apply(RDMISS);
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k == 63) chk("wdog_before", 32'(dwait_err), 32'd0);
      if (k == 64) chk("wdog_at_max", 32'(dwait_err), 32'd1);
    end
    chk("wdog_still_stalled", 32'(ctl), 32'(C_DSTL));
    chk("wdog_sticky", 32'(dwait_err), 32'd1);
    apply(IDLE);
    #2;
    chk("wdog_release", 32'(ctl), 32'(C_NORM));
    step();
    chk("wdog_sticky_after", 32'(dwait_err), 32'd1);
    apply(8'b1100_0001);
    #2;
    chk("halt_cycle", 32'(ctl), 32'(C_HLT));
    step();
    apply(IDLE);
    #2;
    chk("halted_ctl", 32'(ctl), 32'(C_OFF));
    chk("halted_flag", 32'(halt), 32'd1);
    chk("halted_stall_cnt", 32'(stall_cnt), 32'd71);
    apply(8'b0010_1110);
    for (int k = 0; k < 5; k++) step();
    chk("halted_frozen_ctl", 32'(ctl), 32'(C_OFF));
    chk("halted_frozen_cnt", 32'(stall_cnt), 32'd71);
    chk("halted_sticky", 32'(halt), 32'd1);
    chk("halted_err_sticky", 32'(dwait_err), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("halt_rst_flag", 32'(halt), 32'd0);
    chk("halt_rst_err", 32'(dwait_err), 32'd0);
    chk("halt_rst_ctl", 32'(ctl), 32'(C_RST));
    step();
    RST = 1'b0;
    apply(IDLE);
    #2;
    chk("halt_rst_run", 32'(ctl), 32'(C_NORM));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
